// File: rtl/step_ctrl_pkg.sv
// Shared FSM state encoding and default parameter values for the emulator step controller.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STEP     = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_t;

    localparam int DEF_CYCLES_PER_STEP = 1;
    localparam int DEF_CNT_WIDTH       = 32;
    localparam int DEF_T_WIDTH         = 32;
    localparam int DEF_DT_INT          = 1;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a slow asynchronous level coming from the stimulus controller.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/step_ctrl.sv
// Single-step controller: turns each go pulse into a CYCLES_PER_STEP clock-enable burst
// and tracks completed steps and emulated time while the model is out of reset.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int CYCLES_PER_STEP = DEF_CYCLES_PER_STEP,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH,
    parameter int T_WIDTH         = DEF_T_WIDTH,
    parameter int DT_INT          = DEF_DT_INT
) (
    input  logic                 emu_clk,
    input  logic                 emu_rst,
    input  logic                 go_vio,
    input  logic                 rst_vio,
    output logic                 emu_clk_en,
    output logic                 model_rst,
    output logic                 step_done,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] step_count,
    output logic [T_WIDTH-1:0]   t_sim
);

    logic go_s2;
    logic rst_s2;

    sync2 u_sync_go  (.clk(emu_clk), .rst(emu_rst), .d(go_vio),  .q(go_s2));
    sync2 u_sync_rst (.clk(emu_clk), .rst(emu_rst), .d(rst_vio), .q(rst_s2));

    state_t               state_q, state_d;
    logic [7:0]           cyc_q, cyc_d;
    logic                 en_q, en_d;
    logic                 go_prev_q;
    logic                 hold_q, hold_d;
    logic                 model_rst_q, model_rst_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [T_WIDTH-1:0]   t_q, t_d;
    logic                 go_rise;
    logic                 last_cyc;

    assign go_rise  = go_s2 & ~go_prev_q;
    assign last_cyc = (state_q == ST_STEP) && (cyc_q == 8'd0);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        en_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go_rise) begin
                    state_d = ST_STEP;
                    cyc_d   = 8'(CYCLES_PER_STEP - 1);
                    en_d    = 1'b1;
                end
            end
            ST_STEP: begin
                if (cyc_q == 8'd0) begin
                    state_d = ST_WAIT_LOW;
                end else begin
                    cyc_d = cyc_q - 8'd1;
                    en_d  = 1'b1;
                end
            end
            // One step per go pulse: wait for go to drop before re-arming.
            ST_WAIT_LOW: begin
                if (!go_s2) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // After emu_rst, keep the model in reset until synchronized rst_vio has been seen low.
    always_comb begin
        hold_d      = hold_q & rst_s2;
        model_rst_d = rst_s2 | hold_q;
    end

    // A step finishing while model_rst is high is not counted.
    always_comb begin
        cnt_d = cnt_q;
        t_d   = t_q;
        if (model_rst_q) begin
            cnt_d = '0;
            t_d   = '0;
        end else if (last_cyc) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            t_d   = t_q + T_WIDTH'(DT_INT);
        end
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 8'd0;
            en_q        <= 1'b0;
            go_prev_q   <= 1'b0;
            hold_q      <= 1'b1;
            model_rst_q <= 1'b1;
            cnt_q       <= '0;
            t_q         <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            en_q        <= en_d;
            go_prev_q   <= go_s2;
            hold_q      <= hold_d;
            model_rst_q <= model_rst_d;
            cnt_q       <= cnt_d;
            t_q         <= t_d;
        end
    end

    assign emu_clk_en = en_q;
    assign model_rst  = model_rst_q;
    assign step_done  = last_cyc;
    assign busy       = (state_q != ST_IDLE);
    assign step_count = cnt_q;
    assign t_sim      = t_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Bench for step_ctrl: u_a (1 cycle/step) runs a vector table with a result scoreboard,
// u_b (4 cycles/step, 4-bit count, dt 3) runs multi-cycle corner sequences.
module tb_step_ctrl;

    logic clk = 1'b0;
    logic emu_rst;
    logic go_a, rst_a, go_b, rst_b;

    logic        en_a, mrst_a, done_a, busy_a;
    logic [31:0] cnt_a, t_a;
    logic        en_b, mrst_b, done_b, busy_b;
    logic [3:0]  cnt_b;
    logic [31:0] t_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    step_ctrl u_a (
        .emu_clk(clk), .emu_rst(emu_rst), .go_vio(go_a), .rst_vio(rst_a),
        .emu_clk_en(en_a), .model_rst(mrst_a), .step_done(done_a), .busy(busy_a),
        .step_count(cnt_a), .t_sim(t_a)
    );

    step_ctrl #(.CYCLES_PER_STEP(4), .CNT_WIDTH(4), .T_WIDTH(32), .DT_INT(3)) u_b (
        .emu_clk(clk), .emu_rst(emu_rst), .go_vio(go_b), .rst_vio(rst_b),
        .emu_clk_en(en_b), .model_rst(mrst_b), .step_done(done_b), .busy(busy_b),
        .step_count(cnt_b), .t_sim(t_b)
    );

    typedef struct {
        logic        rst;
        int          go_len;
        int          exp_first;
        int          exp_en;
        logic [31:0] exp_cnt;
        logic [31:0] exp_t;
    } vec_t;

    typedef struct {
        logic [31:0] cnt;
        logic [31:0] t;
    } res_t;

    vec_t tbl[7];
    res_t sb_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_a(input vec_t v, input int idx);
        res_t e;
        int   en_n = 0;
        int   first = -1;
        bit   got = 0;
        bit   cmpd = 0;
        if (rst_a !== v.rst) begin
            @(posedge clk); #1 rst_a = v.rst;
            repeat (6) @(posedge clk);
        end
        sb_q.push_back('{v.exp_cnt, v.exp_t});
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1 go_a = (c < v.go_len);
            @(negedge clk);
            if (got && !cmpd) begin
                e = sb_q.pop_front();
                chk($sformatf("a%0d_count", idx), 64'(cnt_a), 64'(e.cnt));
                chk($sformatf("a%0d_tsim", idx), 64'(t_a), 64'(e.t));
                cmpd = 1;
            end
            if (done_a) got = 1;
            if (en_a) begin
                en_n++;
                if (first < 0) first = c;
            end
        end
        if (!cmpd) chk($sformatf("a%0d_done_timeout", idx), 64'(0), 64'(1));
        chk($sformatf("a%0d_first_en", idx), 64'(first), 64'(v.exp_first));
        chk($sformatf("a%0d_en_cycles", idx), 64'(en_n), 64'(v.exp_en));
        chk($sformatf("a%0d_idle_busy", idx), 64'(busy_a), 64'(0));
    endtask

    task automatic run_b(input int go_len, input int ncyc, input int rst_at,
                         output int en_n, output int done_n, output int first,
                         output int busy_n, output int last_busy,
                         output logic [3:0] cnt_ad, output logic [31:0] t_ad);
        bit got = 0;
        bit cmpd = 0;
        en_n = 0; done_n = 0; first = -1; busy_n = 0; last_busy = -1;
        cnt_ad = 4'hx; t_ad = 32'hx;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1 go_b = (c < go_len);
            if (c == rst_at) rst_b = 1'b1;
            @(negedge clk);
            if (got && !cmpd) begin
                cnt_ad = cnt_b;
                t_ad   = t_b;
                cmpd   = 1;
            end
            if (done_b) begin
                got = 1;
                done_n++;
            end
            if (en_b) begin
                en_n++;
                if (first < 0) first = c;
            end
            if (busy_b) begin
                busy_n++;
                last_busy = c;
            end
        end
    endtask

    initial begin
        int en_n, done_n, first, busy_n, last_busy, en_sum;
        logic [3:0]  cad;
        logic [31:0] tad;

        tbl[0] = '{1'b0, 1, 3, 1, 32'd1, 32'd1};
        tbl[1] = '{1'b0, 5, 3, 1, 32'd2, 32'd2};
        tbl[2] = '{1'b1, 2, 3, 1, 32'd0, 32'd0};
        tbl[3] = '{1'b1, 1, 3, 1, 32'd0, 32'd0};
        tbl[4] = '{1'b0, 3, 3, 1, 32'd1, 32'd1};
        tbl[5] = '{1'b0, 1, 3, 1, 32'd2, 32'd2};
        tbl[6] = '{1'b0, 2, 3, 1, 32'd3, 32'd3};

        emu_rst = 1'b1;
        go_a = 1'b0; rst_a = 1'b0; go_b = 1'b0; rst_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_en_a",    64'(en_a),   64'(0));
        chk("rst_busy_a",  64'(busy_a), 64'(0));
        chk("rst_done_a",  64'(done_a), 64'(0));
        chk("rst_count_a", 64'(cnt_a),  64'(0));
        chk("rst_tsim_a",  64'(t_a),    64'(0));
        chk("rst_mrst_a",  64'(mrst_a), 64'(1));
        chk("rst_mrst_b",  64'(mrst_b), 64'(1));
        @(posedge clk); #1 emu_rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("mrst_a_released", 64'(mrst_a), 64'(0));
        chk("mrst_b_released", 64'(mrst_b), 64'(0));

        for (int i = 0; i < 7; i++) run_a(tbl[i], i);
        chk("sb_empty", 64'(sb_q.size()), 64'(0));

        // go held high 20 cycles: one burst, busy until go low + 2
        run_b(20, 26, -1, en_n, done_n, first, busy_n, last_busy, cad, tad);
        chk("b_hold_en",        64'(en_n),      64'(4));
        chk("b_hold_done",      64'(done_n),    64'(1));
        chk("b_hold_first",     64'(first),     64'(3));
        chk("b_hold_busy_n",    64'(busy_n),    64'(20));
        chk("b_hold_last_busy", 64'(last_busy), 64'(22));
        chk("b_hold_count",     64'(cad),       64'(1));
        chk("b_hold_tsim",      64'(tad),       64'(3));

        // rst_vio raised during the burst
        run_b(2, 12, 3, en_n, done_n, first, busy_n, last_busy, cad, tad);
        chk("b_midrst_en",    64'(en_n),   64'(4));
        chk("b_midrst_done",  64'(done_n), 64'(1));
        chk("b_midrst_count", 64'(cad),    64'(0));
        chk("b_midrst_tsim",  64'(tad),    64'(0));
        chk("b_midrst_mrst",  64'(mrst_b), 64'(1));

        en_sum = 0;
        for (int i = 0; i < 3; i++) begin
            run_b(2, 12, -1, en_n, done_n, first, busy_n, last_busy, cad, tad);
            en_sum += en_n;
        end
        chk("b_inrst_en_sum", 64'(en_sum), 64'(12));
        chk("b_inrst_count",  64'(cnt_b),  64'(0));
        chk("b_inrst_tsim",   64'(t_b),    64'(0));
        chk("b_inrst_mrst",   64'(mrst_b), 64'(1));

        @(posedge clk); #1 rst_b = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("b_release_mrst", 64'(mrst_b), 64'(0));

        for (int i = 0; i < 17; i++)
            run_b(2, 12, -1, en_n, done_n, first, busy_n, last_busy, cad, tad);
        chk("b_wrap17_count", 64'(cnt_b), 64'(1));
        chk("b_wrap17_tsim",  64'(t_b),   64'(51));
        for (int i = 0; i < 8; i++)
            run_b(2, 12, -1, en_n, done_n, first, busy_n, last_busy, cad, tad);
        chk("b_25_count", 64'(cnt_b), 64'(9));
        chk("b_25_tsim",  64'(t_b),   64'(75));

        // emu_rst in the 2nd enable cycle aborts the step
        @(posedge clk); #1 go_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("b_abort_en_on", 64'(en_b), 64'(1));
        @(posedge clk); #1 emu_rst = 1'b1;
        @(negedge clk);
        chk("b_abort_en_2nd", 64'(en_b), 64'(1));
        @(posedge clk);
        @(negedge clk);
        chk("b_abort_en",    64'(en_b),   64'(0));
        chk("b_abort_busy",  64'(busy_b), 64'(0));
        chk("b_abort_done",  64'(done_b), 64'(0));
        chk("b_abort_count", 64'(cnt_b),  64'(0));
        chk("b_abort_tsim",  64'(t_b),    64'(0));
        chk("b_abort_mrst",  64'(mrst_b), 64'(1));
        #1 go_b = 1'b0;
        @(posedge clk); #1 emu_rst = 1'b0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
